// File: rtl/char_renderer.sv
// Character renderer: draws one 8x16 glyph cell or clears the screen,
// emitting one pixel per cycle on X/Y/COLOUR/PLOT.
module char_renderer #(
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned TEXT_COLS = 20,
  parameter int unsigned TEXT_ROWS = 7,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         CLEAR,
  input  logic [6:0]   CHAR,
  input  logic [4:0]   COL,
  input  logic [2:0]   ROW,
  output logic [6:0]   CHAR_CODE,
  input  logic [127:0] GLYPH,
  output logic [7:0]   X,
  output logic [6:0]   Y,
  output logic [2:0]   COLOUR,
  output logic         PLOT,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_CLR   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  logic [2:0]   state_q, state_d;
  logic [6:0]   pix_q, pix_d, pix_nxt;
  logic [4:0]   col_q, col_d;
  logic [2:0]   row_q, row_d;
  logic [127:0] glyph_q, glyph_d;
  logic [6:0]   code_q, code_d;
  logic [7:0]   x_q, x_d;
  logic [6:0]   y_q, y_d;
  logic [2:0]   colour_q, colour_d;
  logic         plot_q, plot_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic         cell_ok;

  // Unsupported codes fall back to space; lower case folds to upper case.
  function automatic logic [6:0] map_code(input logic [6:0] c);
    if (c >= 7'd97 && c <= 7'd122) return c - 7'd32;
    if (c == 7'd32 || (c >= 7'd48 && c <= 7'd57) || (c >= 7'd65 && c <= 7'd90)) return c;
    return 7'd32;
  endfunction

  assign cell_ok = (32'(COL) < TEXT_COLS) && (32'(ROW) < TEXT_ROWS);
  assign pix_nxt = pix_q + 7'd1;

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    col_d    = col_q;
    row_d    = row_q;
    glyph_d  = glyph_q;
    code_d   = code_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CLEAR) begin
          state_d  = S_CLR;
          x_d      = 8'd0;
          y_d      = 7'd0;
          colour_d = BG_COLOUR;
          plot_d   = 1'b1;
        end else if (START) begin
          if (cell_ok) begin
            state_d = S_FETCH;
            col_d   = COL;
            row_d   = ROW;
            code_d  = map_code(CHAR);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // First pixel uses the decoder output directly as it is captured.
        glyph_d  = GLYPH;
        state_d  = S_DRAW;
        pix_d    = 7'd0;
        x_d      = {col_q, 3'd0};
        y_d      = {row_q, 4'd0};
        colour_d = GLYPH[127] ? FG_COLOUR : BG_COLOUR;
        plot_d   = 1'b1;
      end
      S_DRAW: begin
        if (pix_q == 7'd127) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          pix_d    = pix_nxt;
          x_d      = {col_q, pix_nxt[2:0]};
          y_d      = {row_q, pix_nxt[6:3]};
          colour_d = glyph_q[~pix_nxt] ? FG_COLOUR : BG_COLOUR;
          plot_d   = 1'b1;
        end
      end
      S_CLR: begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          if (x_q == X_LAST) begin
            x_d = 8'd0;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
          colour_d = BG_COLOUR;
          plot_d   = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      pix_q    <= 7'd0;
      col_q    <= 5'd0;
      row_q    <= 3'd0;
      glyph_q  <= 128'd0;
      code_q   <= 7'd32;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      col_q    <= col_d;
      row_q    <= row_d;
      glyph_q  <= glyph_d;
      code_q   <= code_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign CHAR_CODE = code_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign COLOUR    = colour_q;
  assign PLOT      = plot_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: doc/char_renderer.md
CHAR_RENDERER -- requirements
Module: char_renderer

Interface
REQ-001 Parameter FG_COLOUR, default 3'b111, colour driven for glyph bits equal to 1.
REQ-002 Parameter BG_COLOUR, default 3'b000, colour driven for glyph bits equal to 0 and for clear.
REQ-003 Parameter TEXT_COLS, default 20, number of 8-pixel character columns.
REQ-004 Parameter TEXT_ROWS, default 7, number of 16-pixel character rows.
REQ-005 Parameters SCREEN_W and SCREEN_H, defaults 160 and 120, clear-area pixel dimensions.
REQ-006 CLK  input  1  sole clock; all state changes on rising edge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 START  input  1  request to draw CHAR at cell (COL, ROW); sampled only in IDLE.
REQ-009 CLEAR  input  1  request to fill SCREEN_W x SCREEN_H with BG_COLOUR; sampled only in IDLE.
REQ-010 CHAR  input  7  ASCII code to draw.
REQ-011 COL  input  5  character column.
REQ-012 ROW  input  3  character row.
REQ-013 CHAR_CODE  output  7  registered code driven to the glyph decoder IN.
REQ-014 GLYPH  input  128  decoder OUT; row r = GLYPH[127-8r -: 8]; column c = bit (7-c) of that row.
REQ-015 X  output  8  pixel x coordinate.
REQ-016 Y  output  7  pixel y coordinate.
REQ-017 COLOUR  output  3  pixel colour.
REQ-018 PLOT  output  1  X/Y/COLOUR are valid this cycle; one pixel per cycle.
REQ-019 BUSY  output  1  high in every state other than IDLE.
REQ-020 DONE  output  1  one-cycle pulse at end of a draw or clear.
REQ-021 ERR  output  1  one-cycle pulse when START is rejected.

Function
REQ-022 The block SHALL implement states IDLE, FETCH, DRAW, CLR, FIN.
- IDLE: CLEAR=1 -> CLR; else START=1 with COL<TEXT_COLS and ROW<TEXT_ROWS -> FETCH; else START=1 -> ERR pulse next cycle, stay IDLE.
- FETCH: one cycle -> DRAW.
- DRAW: 128 cycles -> FIN.
- CLR: SCREEN_W*SCREEN_H cycles -> FIN.
- FIN: one cycle -> IDLE.
REQ-023 On START acceptance, CHAR/COL/ROW SHALL be latched; later input changes SHALL not affect the operation.
REQ-024 CHAR_CODE SHALL be the latched CHAR, except 97..122 map to CHAR-32 and codes outside {32, 48..57, 65..90} map to 7'd32.
REQ-025 GLYPH SHALL be registered at the end of FETCH and held constant through DRAW.
REQ-026 DRAW SHALL emit pixels row-major, r=0..15 outer, c=0..7 inner: X=COL*8+c, Y=ROW*16+r, COLOUR=FG_COLOUR if the glyph bit is 1, else BG_COLOUR, PLOT=1.
REQ-027 Latency: START accepted at edge k -> FETCH cycle k+1, PLOTs cycles k+2..k+129, DONE and FIN cycle k+130, IDLE at k+131.
REQ-028 CLR SHALL emit X=0..SCREEN_W-1 inner and Y=0..SCREEN_H-1 outer, COLOUR=BG_COLOUR, PLOT=1, then FIN with DONE.
REQ-029 START or CLEAR while BUSY=1 SHALL be ignored and not queued.
REQ-030 START and CLEAR together in IDLE: CLEAR wins, no ERR.
REQ-031 PLOT SHALL be 0 in IDLE, FETCH and FIN; DONE is high only in FIN; ERR is never high while BUSY=1.
REQ-032 Counters SHALL not wrap past their terminal values; the last pixel is (7,15) of the glyph or (SCREEN_W-1, SCREEN_H-1).

Reset
REQ-033 RESET=1 SHALL immediately force IDLE, X=0, Y=0, COLOUR=0, CHAR_CODE=7'd32, PLOT=0, BUSY=0, DONE=0, ERR=0, glyph register=0, including mid-DRAW or mid-CLR.
REQ-034 After RESET deasserts, the first START or CLEAR SHALL be accepted on the next rising edge.

Verification
REQ-035 START, CHAR=65, COL=2, ROW=1 -> 128 PLOTs starting cycle k+2; row r=1 gives FG at X=19,20 (Y=17) and BG elsewhere; DONE at k+130.
REQ-036 CHAR=97 -> CHAR_CODE=65; CHAR=33 -> CHAR_CODE=32 and all 128 pixels BG.
REQ-037 START with COL=20 -> ERR pulse, no PLOT, BUSY stays 0.
REQ-038 CLEAR -> exactly 19200 PLOTs, first (0,0), last (159,119), all COLOUR=0; START during clear is ignored.
REQ-039 START and CLEAR in the same cycle -> clear sequence, no glyph pixels.
REQ-040 RESET asserted at the 50th DRAW pixel -> PLOT=0 and BUSY=0 immediately; next START gives a full 128-pixel draw.
